// File: rtl/loop_issue.sv
// Counted-loop issuer: walks an index from 0 by step while it stays below bound,
// offering each index over a valid/ready handshake and flagging the final one.
module loop_issue #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bound,
    input  logic [WIDTH-1:0] step,
    input  logic             iter_ready,
    output logic             iter_valid,
    output logic [WIDTH-1:0] iter_idx,
    output logic             iter_last,
    output logic             busy,
    output logic             finish,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE, ERR} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] idx_reg;
    logic [WIDTH-1:0] bound_reg;
    logic [WIDTH-1:0] step_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             finish_reg;
    logic             err_reg;

    logic [WIDTH:0]   sum_next;
    logic             at_end;
    logic             start_ok;
    logic             xfer;

    // One extra bit on the sum so an index near the top of the range never wraps
    // back below bound and spins forever.
    assign sum_next = {1'b0, idx_reg} + {1'b0, step_reg};
    assign at_end   = (sum_next >= {1'b0, bound_reg});
    assign start_ok = start && (state_reg != ISSUE);
    assign xfer     = valid_reg && iter_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            bound_reg  <= '0;
            step_reg   <= '0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            finish_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else if (start_ok) begin
            bound_reg  <= bound;
            step_reg   <= step;
            idx_reg    <= '0;
            finish_reg <= 1'b0;
            err_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            if (step == '0) begin
                state_reg <= ERR;
                err_reg   <= 1'b1;
            end else if (bound == '0) begin
                state_reg  <= DONE;
                finish_reg <= 1'b1;
            end else begin
                state_reg <= ISSUE;
                valid_reg <= 1'b1;
                busy_reg  <= 1'b1;
            end
        end else if (state_reg == ISSUE && xfer) begin
            if (at_end) begin
                state_reg  <= DONE;
                valid_reg  <= 1'b0;
                busy_reg   <= 1'b0;
                finish_reg <= 1'b1;
            end else begin
                idx_reg <= sum_next[WIDTH-1:0];
            end
        end
    end

    assign iter_valid = valid_reg;
    assign iter_idx   = idx_reg;
    assign iter_last  = valid_reg & at_end;
    assign busy       = busy_reg;
    assign finish     = finish_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_loop_issue.sv
// Bench for loop_issue: directed corner loops plus random loops, with a
// queue-based scoreboard fed by the stimulus and drained by an output monitor.
`timescale 1ns/1ps
module tb_loop_issue;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] step;
    logic             iter_ready;
    logic             iter_valid;
    logic [WIDTH-1:0] iter_idx;
    logic             iter_last;
    logic             busy;
    logic             finish;
    logic             err;

    typedef struct {
        int idx;
        bit last;
    } item_t;

    item_t exp_q[$];
    int    asserts  = 0;
    int    failures = 0;
    int    xfers    = 0;

    loop_issue #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bound      (bound),
        .step       (step),
        .iter_ready (iter_ready),
        .iter_valid (iter_valid),
        .iter_idx   (iter_idx),
        .iter_last  (iter_last),
        .busy       (busy),
        .finish     (finish),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and
    // ready are both seen high here, unless reset wins that edge.
    initial begin
        bit               stalled;
        logic [WIDTH-1:0] held_idx;
        logic             held_last;
        stalled = 1'b0;
        held_idx = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                stalled = 1'b0;
            end else begin
                if (stalled && iter_valid === 1'b1) begin
                    check("stall_idx_hold", iter_idx, held_idx);
                    check("stall_last_hold", iter_last, held_last);
                end
                stalled = 1'b0;
                if (iter_valid === 1'b1 && iter_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", iter_valid, 0);
                    end else begin
                        item_t e;
                        e = exp_q.pop_front();
                        check("xfer_idx", iter_idx, e.idx);
                        check("xfer_last", iter_last, e.last);
                        xfers++;
                    end
                end else if (iter_valid === 1'b1) begin
                    stalled   = 1'b1;
                    held_idx  = iter_idx;
                    held_last = iter_last;
                end
            end
        end
    end

    // mode 0: ready always high; mode 1: ready 1,0,0,1,1 then high;
    // mode 2: random ready plus a stray start pulse mid-loop that must be ignored.
    task automatic run_loop(input int b, input int s, input int mode, input int exp_busy);
        int k;
        int busy_cycles;
        int x0;
        int n_exp;
        int pat[5] = '{1, 0, 0, 1, 1};
        n_exp = 0;
        if (s != 0) begin
            for (int i = 0; i < b; i += s) begin
                item_t e;
                e.idx  = i;
                e.last = (i + s >= b);
                exp_q.push_back(e);
                n_exp++;
            end
        end
        x0    = xfers;
        bound = b[WIDTH-1:0];
        step  = s[WIDTH-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_after_start", err, (s == 0));
        check("finish_after_start", finish, (s != 0 && b == 0));
        busy_cycles = 0;
        k = 0;
        while (busy === 1'b1 && k < 2000) begin
            busy_cycles++;
            if (mode == 1 && (k == 1 || k == 2))
                check("stall_idx_is_3", iter_idx, 3);
            case (mode)
                0:       iter_ready = 1'b1;
                1:       iter_ready = (k < 5) ? pat[k][0] : 1'b1;
                default: iter_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 2 && k == 1) begin
                start = 1'b1;
                bound = WIDTH'($urandom);
                step  = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
            k++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("loop_terminated", busy, 0);
        check("xfer_count", xfers - x0, n_exp);
        if (exp_busy >= 0)
            check("busy_cycles", busy_cycles, exp_busy);
        check("finish_end", finish, (s != 0));
        check("err_end", err, (s == 0));
        check("valid_end", iter_valid, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("loop bound=%0d step=%0d mode=%0d transfers=%0d busy_cycles=%0d finish=%0b err=%0b",
                 b, s, mode, xfers - x0, busy_cycles, finish, err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, iter_valid, 0);
        check({tag, "_idx"}, iter_idx, 0);
        check({tag, "_last"}, iter_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finish"}, finish, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic reset_mid_loop();
        int x0;
        for (int i = 0; i < 10; i++) begin
            item_t e;
            e.idx  = i;
            e.last = (i == 9);
            exp_q.push_back(e);
        end
        x0         = xfers;
        bound      = 8'd10;
        step       = 8'd1;
        iter_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("xfers_before_rst", xfers - x0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("mid_rst");
        exp_q.delete();
        rst = 1'b0;
        $display("reset mid-loop after %0d transfers", xfers - x0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        iter_ready = 1'b0;
        bound      = '0;
        step       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        run_loop(2, 1, 0, 2);
        run_loop(7, 3, 1, 5);
        run_loop(255, 16, 0, 16);
        run_loop(0, 1, 0, 0);
        run_loop(5, 0, 0, 0);
        run_loop(3, 1, 0, 3);
        reset_mid_loop();
        run_loop(10, 1, 0, 10);

        for (int n = 0; n < 25; n++) begin
            int b;
            int s;
            b = $urandom_range(0, 255);
            s = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            run_loop(b, s, 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/loop_issue.md
LOOP_ISSUE -- requirements
Module: loop_issue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of the loop index, bound and step.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to launch a loop.
REQ-005 The block SHALL have port bound, input, WIDTH bits: exclusive upper limit of the index; sampled only when start is accepted.
REQ-006 The block SHALL have port step, input, WIDTH bits: index increment; sampled only when start is accepted.
REQ-007 The block SHALL have port iter_ready, input, 1 bit: the downstream stage can accept an iteration.
REQ-008 The block SHALL have port iter_valid, output, 1 bit: an iteration is offered.
REQ-009 The block SHALL have port iter_idx, output, WIDTH bits: index of the offered iteration.
REQ-010 The block SHALL have port iter_last, output, 1 bit: the offered iteration is the final one.
REQ-011 The block SHALL have port busy, output, 1 bit: a loop is in progress.
REQ-012 The block SHALL have port finish, output, 1 bit: the loop has completed; a held level.
REQ-013 The block SHALL have port err, output, 1 bit: the last loop was rejected because step was 0; a held level.

Function
REQ-014 The block SHALL implement four states: IDLE, ISSUE, DONE and ERR; state is registered.
REQ-015 start SHALL be accepted only in IDLE, DONE or ERR; start in ISSUE SHALL be ignored, with no capture and no state change.
REQ-016 On an accepted start, the block SHALL register bound and step, set the index to 0, and clear finish and err on the next edge.
REQ-017 On an accepted start with step == 0, the next state SHALL be ERR; this check takes priority over REQ-018.
REQ-018 On an accepted start with step != 0 and bound == 0, the next state SHALL be DONE and no iteration SHALL be issued.
REQ-019 On an accepted start with step != 0 and bound != 0, the next state SHALL be ISSUE.
REQ-020 In ISSUE, iter_valid SHALL be 1, iter_idx SHALL equal the registered index, and busy SHALL be 1; iter_valid SHALL be 0 in every other state.
REQ-021 Handshake: an iteration transfers on a rising edge where iter_valid and iter_ready are both 1; iter_valid may be asserted regardless of iter_ready.
REQ-022 While iter_valid is 1 and iter_ready is 0, iter_idx and iter_last SHALL hold stable.
REQ-023 The next index SHALL be computed as index + step in WIDTH+1 bits, so that no wrap-around occurs.
REQ-024 iter_last SHALL equal iter_valid AND (index + step >= bound), using the WIDTH+1-bit sum.
REQ-025 On a transfer with iter_last == 0, the index SHALL advance by step and the block SHALL stay in ISSUE.
REQ-026 On a transfer with iter_last == 1, the next state SHALL be DONE.
REQ-027 The number of transfers per loop SHALL be ceil(bound/step); the issued indices SHALL be 0, step, 2*step, and so on, each less than bound.
REQ-028 Throughput: one iteration per cycle SHALL be achieved while iter_ready is held at 1.
REQ-029 finish SHALL be 1 exactly when the state is DONE, held until the next accepted start or rst.
REQ-030 err SHALL be 1 exactly when the state is ERR, held until the next accepted start or rst.
REQ-031 busy SHALL be 1 only in ISSUE.
REQ-032 A start that arrives in the same cycle as the final transfer SHALL be ignored, because the state is still ISSUE.

Reset
REQ-033 rst == 1 at a rising edge SHALL force the following: state IDLE, index 0, registered bound and step 0, iter_valid 0, iter_last 0, busy 0, finish 0, err 0.
REQ-034 rst SHALL take priority over start and over the handshake in the same cycle.
REQ-035 rst asserted mid-loop SHALL abort the loop with no further transfers; any pending iteration SHALL be dropped.
REQ-036 After reset, the block SHALL be fully operational on the first cycle with rst == 0.

Verification
REQ-037 The bench SHALL cover: bound=2, step=1, iter_ready=1 -> transfers idx 0 then idx 1 with iter_last=1 on idx 1; finish=1 on the following cycle; busy high for 2 cycles.
REQ-038 The bench SHALL cover: bound=7, step=3, iter_ready toggling 1,0,0,1,1 -> transfers 0, 3, 6 only; idx is held at 3 during the stall; iter_last=1 only at idx 6.
REQ-039 The bench SHALL cover: WIDTH=8, bound=255, step=16 -> 16 transfers 0..240; iter_last=1 at 240 (the sum 256 in 9 bits causes no wrap); then finish=1.
REQ-040 The bench SHALL cover: bound=0, step=1 -> iter_valid never 1; finish=1 one cycle after start.
REQ-041 The bench SHALL cover: step=0, bound=5 -> state ERR, err=1, finish=0, no transfers; a subsequent start with step=1 clears err.
REQ-042 The bench SHALL cover: rst asserted after the 2nd transfer of bound=10, step=1 -> all outputs are 0 on the next edge; a fresh start restarts the loop from idx 0.
